// File: rtl/cam_ctrl.sv
// Sequencing controller and round-robin arbiter for a flip-flop based CAM.
// Optional flush support is enabled by defining CAM_FLUSH_EN (adds the flush_req port).
module cam_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef CAM_FLUSH_EN
  input  logic                   flush_req,
`endif
  input  logic                   ins_req,
  input  logic [WIDTH-1:0]       ins_key,
  output logic                   ins_gnt,
  input  logic                   del_req,
  input  logic [WIDTH-1:0]       del_key,
  output logic                   del_gnt,
  input  logic                   srch_req,
  input  logic [WIDTH-1:0]       srch_key,
  output logic                   srch_gnt,
  output logic [WIDTH-1:0]       ff_data_i,
  output logic [DEPTH-1:0]       ff_load,
  output logic                   ff_rst,
  input  logic [DEPTH*WIDTH-1:0] ff_data_o,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_op,
  output logic                   rsp_hit,
  output logic [IDX_W-1:0]       rsp_idx,
  output logic                   rsp_err,
  output logic [IDX_W:0]         count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;

  localparam logic [1:0] OP_INS  = 2'd0;
  localparam logic [1:0] OP_DEL  = 2'd1;
  localparam logic [1:0] OP_SRCH = 2'd2;
`ifdef CAM_FLUSH_EN
  localparam logic [1:0] OP_FLUSH = 2'd3;
`endif

  logic [1:0]       state_reg;
  logic [1:0]       rr_ptr_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] key_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] match_reg;
  logic [DEPTH-1:0] match_next;
  logic [IDX_W:0]   count_reg;

  logic [3:0]       req_vec;
  logic [1:0]       cand1;
  logic [1:0]       cand2;
  logic             grant_any;
  logic [1:0]       grant_sel;
  logic [WIDTH-1:0] grant_key;

  logic             ex_hit;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] free_idx;
  logic [DEPTH-1:0] free_onehot;
  logic [DEPTH-1:0] hit_onehot;

  assign count = count_reg;
  assign full  = (count_reg == (IDX_W+1)'(DEPTH));
  assign empty = (count_reg == '0);

`ifdef CAM_FLUSH_EN
  logic flush_pulse_reg;
  assign ff_rst = reset | flush_pulse_reg;
`else
  assign ff_rst = reset;
`endif

  // Round-robin: try rr_ptr first, then the two requesters after it.
  assign req_vec = {1'b0, srch_req, del_req, ins_req};

  always_comb begin
    cand1     = (rr_ptr_reg == 2'd2) ? 2'd0 : rr_ptr_reg + 2'd1;
    cand2     = (rr_ptr_reg == 2'd0) ? 2'd2 : rr_ptr_reg - 2'd1;
    grant_any = 1'b0;
    grant_sel = 2'd0;
    if (req_vec[rr_ptr_reg]) begin
      grant_any = 1'b1;
      grant_sel = rr_ptr_reg;
    end else if (req_vec[cand1]) begin
      grant_any = 1'b1;
      grant_sel = cand1;
    end else if (req_vec[cand2]) begin
      grant_any = 1'b1;
      grant_sel = cand2;
    end
  end

  always_comb begin
    case (grant_sel)
      OP_DEL:  grant_key = del_key;
      OP_SRCH: grant_key = srch_key;
      default: grant_key = ins_key;
    endcase
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match_next[gi] = valid_reg[gi] && (ff_data_o[gi*WIDTH +: WIDTH] == key_reg);
  end

  // Lowest-index priority for both the matched entry and the free slot.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_reg[i]) hit_idx = IDX_W'(i);
      if (!valid_reg[i]) free_idx = IDX_W'(i);
    end
  end

  assign ex_hit      = |match_reg;
  assign free_onehot = DEPTH'(1) << free_idx;
  assign hit_onehot  = DEPTH'(1) << hit_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      rr_ptr_reg <= 2'd0;
      op_reg     <= 2'd0;
      key_reg    <= '0;
      valid_reg  <= '0;
      match_reg  <= '0;
      count_reg  <= '0;
      ins_gnt    <= 1'b0;
      del_gnt    <= 1'b0;
      srch_gnt   <= 1'b0;
      ff_data_i  <= '0;
      ff_load    <= '0;
      rsp_valid  <= 1'b0;
      rsp_op     <= 2'd0;
      rsp_hit    <= 1'b0;
      rsp_idx    <= '0;
      rsp_err    <= 1'b0;
`ifdef CAM_FLUSH_EN
      flush_pulse_reg <= 1'b0;
`endif
    end else begin
      ins_gnt   <= 1'b0;
      del_gnt   <= 1'b0;
      srch_gnt  <= 1'b0;
      ff_load   <= '0;
      rsp_valid <= 1'b0;
      rsp_op    <= 2'd0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
      rsp_err   <= 1'b0;
`ifdef CAM_FLUSH_EN
      flush_pulse_reg <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
`ifdef CAM_FLUSH_EN
          if (flush_req) begin
            flush_pulse_reg <= 1'b1;
            valid_reg       <= '0;
            count_reg       <= '0;
            op_reg          <= OP_FLUSH;
            state_reg       <= S_EXEC;
          end else
`endif
          if (grant_any) begin
            op_reg     <= grant_sel;
            key_reg    <= grant_key;
            rr_ptr_reg <= (grant_sel == 2'd2) ? 2'd0 : grant_sel + 2'd1;
            ins_gnt    <= (grant_sel == OP_INS);
            del_gnt    <= (grant_sel == OP_DEL);
            srch_gnt   <= (grant_sel == OP_SRCH);
            state_reg  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          match_reg <= match_next;
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          state_reg <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_op    <= op_reg;
          case (op_reg)
            OP_INS: begin
              if (ex_hit) begin
                rsp_hit <= 1'b1;
                rsp_idx <= hit_idx;
              end else if (!full) begin
                ff_data_i <= key_reg;
                ff_load   <= free_onehot;
                valid_reg <= valid_reg | free_onehot;
                count_reg <= count_reg + 1'b1;
                rsp_idx   <= free_idx;
              end else begin
                rsp_err <= 1'b1;
              end
            end
            OP_DEL: begin
              if (ex_hit) begin
                valid_reg <= valid_reg & ~hit_onehot;
                count_reg <= count_reg - 1'b1;
                rsp_hit   <= 1'b1;
                rsp_idx   <= hit_idx;
              end
            end
            OP_SRCH: begin
              rsp_hit <= ex_hit;
              rsp_idx <= ex_hit ? hit_idx : '0;
            end
            default: ;
          endcase
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed self-checking bench for cam_ctrl with a behavioural model of the register array.
module tb_cam_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ins_req, del_req, srch_req;
  logic [7:0]  ins_key, del_key, srch_key;
  logic        ins_gnt, del_gnt, srch_gnt;
  logic [7:0]  ff_data_i;
  logic [7:0]  ff_load;
  logic        ff_rst;
  logic [63:0] ff_data_o;
  logic        rsp_valid;
  logic [1:0]  rsp_op;
  logic        rsp_hit;
  logic [2:0]  rsp_idx;
  logic        rsp_err;
  logic [3:0]  count;
  logic        full, empty;
`ifdef CAM_FLUSH_EN
  logic        flush_req;
`endif

  int total = 0;
  int bad   = 0;

  int         r_glat, r_rlat;
  logic       r_gnt, r_valid, r_hit, r_err;
  logic [1:0] r_op;
  logic [2:0] r_idx;
  logic [7:0] r_load, r_data;
  logic [3:0] r_count;

  logic [7:0] mem [8];

  always #5 clk = ~clk;

  cam_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CAM_FLUSH_EN
    .flush_req (flush_req),
`endif
    .ins_req   (ins_req),
    .ins_key   (ins_key),
    .ins_gnt   (ins_gnt),
    .del_req   (del_req),
    .del_key   (del_key),
    .del_gnt   (del_gnt),
    .srch_req  (srch_req),
    .srch_key  (srch_key),
    .srch_gnt  (srch_gnt),
    .ff_data_i (ff_data_i),
    .ff_load   (ff_load),
    .ff_rst    (ff_rst),
    .ff_data_o (ff_data_o),
    .rsp_valid (rsp_valid),
    .rsp_op    (rsp_op),
    .rsp_hit   (rsp_hit),
    .rsp_idx   (rsp_idx),
    .rsp_err   (rsp_err),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Storage registers driven by the controller's strobes.
  always @(posedge clk or posedge ff_rst) begin
    if (ff_rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) if (ff_load[i]) mem[i] <= ff_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) ff_data_o[i*8 +: 8] = mem[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge in IDLE; returns at the negedge showing rsp_valid.
  task automatic run_op(input logic [1:0] op, input logic [7:0] key);
    int n;
    logic g;
    case (op)
      2'd0: begin ins_req = 1'b1; ins_key = key; end
      2'd1: begin del_req = 1'b1; del_key = key; end
      default: begin srch_req = 1'b1; srch_key = key; end
    endcase
    n = 0;
    g = 1'b0;
    while (!g && n < 8) begin
      @(negedge clk);
      n++;
      g = (op == 2'd0) ? ins_gnt : (op == 2'd1) ? del_gnt : srch_gnt;
    end
    ins_req  = 1'b0;
    del_req  = 1'b0;
    srch_req = 1'b0;
    r_gnt  = g;
    r_glat = n;
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    r_rlat  = n;
    r_valid = rsp_valid;
    r_op    = rsp_op;
    r_hit   = rsp_hit;
    r_idx   = rsp_idx;
    r_err   = rsp_err;
    r_load  = ff_load;
    r_data  = ff_data_i;
    r_count = count;
    chk("gnt_seen", {31'd0, r_gnt}, 1);
    chk("rsp_seen", {31'd0, r_valid}, 1);
    chk("rsp_op", {30'd0, r_op}, {30'd0, op});
  endtask

  int         ng, nr, seen;
  logic [2:0] gid [4];
  int         gcyc [4];
  logic [1:0] rop [4];
  int         rcyc [4];
  logic [2:0] ids_exp [4];
  logic [1:0] ops_exp [4];

  initial begin
    ids_exp[0] = 3'b001; ids_exp[1] = 3'b010; ids_exp[2] = 3'b100; ids_exp[3] = 3'b001;
    ops_exp[0] = 2'd0;   ops_exp[1] = 2'd1;   ops_exp[2] = 2'd2;   ops_exp[3] = 2'd0;
    reset = 1'b1;
    ins_req = 1'b0; del_req = 1'b0; srch_req = 1'b0;
    ins_key = 8'h00; del_key = 8'h00; srch_key = 8'h00;
`ifdef CAM_FLUSH_EN
    flush_req = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ff_rst", {31'd0, ff_rst}, 1);
    chk("rst_count", {28'd0, count}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_gnts", {29'd0, srch_gnt, del_gnt, ins_gnt}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_load", {24'd0, ff_load}, 0);
    chk("rst_data", {24'd0, ff_data_i}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ff_rst_release", {31'd0, ff_rst}, 0);

    // First insert into empty table
    run_op(2'd0, 8'h3C);
    $display("ins 3C: hit=%0d idx=%0d err=%0d load=%02h count=%0d", r_hit, r_idx, r_err, r_load, r_count);
    chk("ins_glat", r_glat, 1);
    chk("ins_rlat", r_rlat, 2);
    chk("ins_load", {24'd0, r_load}, 32'h01);
    chk("ins_data", {24'd0, r_data}, 32'h3C);
    chk("ins_hit", {31'd0, r_hit}, 0);
    chk("ins_idx", {29'd0, r_idx}, 0);
    chk("ins_count", {28'd0, r_count}, 1);
    chk("ins_empty", {31'd0, empty}, 0);

    // Duplicate insert
    run_op(2'd0, 8'h3C);
    $display("ins 3C dup: hit=%0d idx=%0d load=%02h count=%0d", r_hit, r_idx, r_load, r_count);
    chk("dup_hit", {31'd0, r_hit}, 1);
    chk("dup_idx", {29'd0, r_idx}, 0);
    chk("dup_load", {24'd0, r_load}, 0);
    chk("dup_count", {28'd0, r_count}, 1);

    // Fill remaining slots with 0x11..0x77
    for (int k = 1; k < 8; k++) begin
      run_op(2'd0, 8'(k * 8'h11));
      $display("ins %02h: idx=%0d load=%02h count=%0d", 8'(k * 8'h11), r_idx, r_load, r_count);
      chk("fill_idx", {29'd0, r_idx}, k);
      chk("fill_load", {24'd0, r_load}, 32'd1 << k);
    end
    chk("fill_count", {28'd0, count}, 8);
    chk("fill_full", {31'd0, full}, 1);

    // Insert into full table
    run_op(2'd0, 8'h99);
    $display("ins 99 full: err=%0d idx=%0d load=%02h count=%0d", r_err, r_idx, r_load, r_count);
    chk("full_err", {31'd0, r_err}, 1);
    chk("full_idx", {29'd0, r_idx}, 0);
    chk("full_hit", {31'd0, r_hit}, 0);
    chk("full_load", {24'd0, r_load}, 0);
    chk("full_count", {28'd0, r_count}, 8);

    // Delete idx 3, then reinsert 0x99 there
    run_op(2'd1, 8'h33);
    $display("del 33: hit=%0d idx=%0d err=%0d count=%0d", r_hit, r_idx, r_err, r_count);
    chk("del_hit", {31'd0, r_hit}, 1);
    chk("del_idx", {29'd0, r_idx}, 3);
    chk("del_err", {31'd0, r_err}, 0);
    chk("del_load", {24'd0, r_load}, 0);
    chk("del_count", {28'd0, r_count}, 7);
    run_op(2'd0, 8'h99);
    $display("ins 99: idx=%0d load=%02h data=%02h count=%0d", r_idx, r_load, r_data, r_count);
    chk("reins_idx", {29'd0, r_idx}, 3);
    chk("reins_load", {24'd0, r_load}, 32'h08);
    chk("reins_data", {24'd0, r_data}, 32'h99);
    chk("reins_count", {28'd0, r_count}, 8);

    // Delete idx 5, search it, delete-miss, search idx 2
    run_op(2'd1, 8'h55);
    $display("del 55: hit=%0d idx=%0d count=%0d", r_hit, r_idx, r_count);
    chk("del5_idx", {29'd0, r_idx}, 5);
    chk("del5_count", {28'd0, r_count}, 7);
    run_op(2'd2, 8'h55);
    $display("srch 55: hit=%0d idx=%0d err=%0d", r_hit, r_idx, r_err);
    chk("srch_del_hit", {31'd0, r_hit}, 0);
    chk("srch_del_idx", {29'd0, r_idx}, 0);
    chk("srch_err", {31'd0, r_err}, 0);
    run_op(2'd1, 8'h55);
    $display("del 55 miss: hit=%0d idx=%0d count=%0d", r_hit, r_idx, r_count);
    chk("delmiss_hit", {31'd0, r_hit}, 0);
    chk("delmiss_count", {28'd0, r_count}, 7);
    run_op(2'd2, 8'h22);
    $display("srch 22: hit=%0d idx=%0d count=%0d", r_hit, r_idx, r_count);
    chk("srch_hit", {31'd0, r_hit}, 1);
    chk("srch_idx", {29'd0, r_idx}, 2);
    chk("srch_count", {28'd0, r_count}, 7);

    // Round-robin with all three requests held
    ins_key = 8'h3C; del_key = 8'hEE; srch_key = 8'h22;
    ins_req = 1'b1; del_req = 1'b1; srch_req = 1'b1;
    ng = 0;
    nr = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (ins_gnt | del_gnt | srch_gnt) begin
        if (ng < 4) begin
          gid[ng]  = {srch_gnt, del_gnt, ins_gnt};
          gcyc[ng] = c;
        end
        ng++;
        if (ng == 4) begin
          ins_req = 1'b0; del_req = 1'b0; srch_req = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (nr < 4) begin
          rop[nr]  = rsp_op;
          rcyc[nr] = c;
        end
        nr++;
      end
    end
    ins_req = 1'b0; del_req = 1'b0; srch_req = 1'b0;
    chk("rr_ngrants", ng, 4);
    chk("rr_nrsp", nr, 4);
    for (int i = 0; i < 4 && i < ng && i < nr; i++) begin
      $display("rr %0d: gnt=%b at %0d rsp_op=%0d at %0d", i, gid[i], gcyc[i], rop[i], rcyc[i]);
      chk("rr_gid", {29'd0, gid[i]}, {29'd0, ids_exp[i]});
      chk("rr_gcyc", gcyc[i], 1 + 3 * i);
      chk("rr_rop", {30'd0, rop[i]}, {30'd0, ops_exp[i]});
      chk("rr_rcyc", rcyc[i], 3 + 3 * i);
    end
    chk("rr_count", {28'd0, count}, 7);

    // Reset during LOOKUP of an insert
    ins_req = 1'b1;
    ins_key = 8'h42;
    @(negedge clk);
    chk("rstop_gnt", {31'd0, ins_gnt}, 1);
    ins_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstop_load", {24'd0, ff_load}, 0);
    chk("rstop_count", {28'd0, count}, 0);
    chk("rstop_empty", {31'd0, empty}, 1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid || ff_load != 8'h00) seen++;
    end
    $display("reset mid-op: count=%0d empty=%0d late_events=%0d", count, empty, seen);
    chk("rstop_norsp", seen, 0);
    chk("rstop_count2", {28'd0, count}, 0);

`ifdef CAM_FLUSH_EN
    for (int k = 1; k <= 4; k++) run_op(2'd0, 8'(8'hA0 + k));
    chk("fl_pre_count", {28'd0, count}, 4);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("fl_ff_rst", {31'd0, ff_rst}, 1);
    chk("fl_count", {28'd0, count}, 0);
    chk("fl_gnt1", {29'd0, srch_gnt, del_gnt, ins_gnt}, 0);
    @(negedge clk);
    $display("flush: rsp_valid=%0d op=%0d hit=%0d idx=%0d err=%0d", rsp_valid, rsp_op, rsp_hit, rsp_idx, rsp_err);
    chk("fl_rsp_valid", {31'd0, rsp_valid}, 1);
    chk("fl_rsp_op", {30'd0, rsp_op}, 3);
    chk("fl_rsp_flags", {27'd0, rsp_hit, rsp_err, rsp_idx}, 0);
    chk("fl_ff_rst_off", {31'd0, ff_rst}, 0);
    chk("fl_gnt2", {29'd0, srch_gnt, del_gnt, ins_gnt}, 0);
    chk("fl_empty", {31'd0, empty}, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
